// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
package program_loader_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // States in which the loader is waiting for a stream byte.
  function automatic logic is_rx_state(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHECK);
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// rtl/loader_timeout_counter.sv - idle-cycle counter that flags a stalled stream
module loader_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturates at TIMEOUT so expired stays asserted until cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed image into instruction memory
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [15:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int IDX_W = $clog2(MEM_WORDS + 1);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              start;
  logic [1:0]        err_set;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       len_rx;
  logic [7:0]        data_hi;
  logic [7:0]        csum;
  logic [IDX_W-1:0]  index;
  logic              timer_enable;
  logic              timer_clear;
  logic              timer_expired;

  assign rx_ready = is_rx_state(state);
  assign accept   = rx_valid && rx_ready;
  assign len_rx   = {len_hi, rx_byte};

  loader_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  (timer_enable),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    err_set      = ERR_NONE;
    timer_enable = rx_ready && !accept;
    timer_clear  = !rx_ready || accept;
    done         = (state == DONE);
    error        = (state == ERR);
    cpu_hold     = (state != DONE);

    case (state)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_nxt = LEN_HI;
          start     = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (len_rx == 16'd0) begin
            state_nxt = CHECK;
          end else if (len_rx > 16'(MEM_WORDS)) begin
            state_nxt = ERR;
            err_set   = ERR_LEN;
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        if (accept) begin
          state_nxt = (16'(index) + 16'd1 == len) ? CHECK : DATA_HI;
        end
      end
      CHECK: begin
        if (accept) begin
          if (rx_byte == csum) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ERR;
            err_set   = ERR_CSUM;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A byte arriving on the expiry cycle still counts; only a silent stream times out.
    if (rx_ready && !accept && timer_expired) begin
      state_nxt = ERR;
      err_set   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= 16'd0;
      imem_wdata <= '0;
      err_code   <= ERR_NONE;
      len_hi     <= 8'd0;
      len        <= 16'd0;
      data_hi    <= 8'd0;
      csum       <= 8'd0;
      index      <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        index    <= '0;
        csum     <= 8'd0;
        err_code <= ERR_NONE;
      end
      if (err_set != ERR_NONE) begin
        err_code <= err_set;
      end
      if (accept) begin
        case (state)
          LEN_HI: len_hi <= rx_byte;
          LEN_LO: len    <= len_rx;
          DATA_HI: begin
            data_hi <= rx_byte;
            csum    <= csum ^ rx_byte;
          end
          DATA_LO: begin
            imem_we    <= 1'b1;
            imem_wdata <= {data_hi, rx_byte};
            imem_addr  <= 16'({index, 1'b0});
            index      <= index + IDX_W'(1);
            csum       <= csum ^ rx_byte;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_wr[$];

  program_loader #(.MEM_WORDS(256), .TIMEOUT(1024)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write must match the next word the model predicted, in order.
  always @(negedge clock) begin
    wr_t w;
    if (reset) begin
      if (imem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = exp_wr.pop_front();
          chk("imem_addr", 32'(imem_addr), 32'(w.addr));
          chk("imem_wdata", 32'(imem_wdata), 32'(w.data));
        end
      end
      chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
      chk("code_vs_error", 32'(err_code != 2'd0), 32'(error));
    end
  end

  function automatic logic [7:0] model_csum(input bq_t s, input int n);
    logic [7:0] c = 8'd0;
    for (int i = 0; i < 2 * n; i++) c ^= s[2 + i];
    return c;
  endfunction

  task automatic model_push(input bq_t s, output logic ok, output logic [1:0] code);
    int n;
    n = {s[0], s[1]};
    if (n > 256) begin
      ok = 1'b0;
      code = 2'd1;
    end else begin
      for (int i = 0; i < n; i++) exp_wr.push_back('{16'(2 * i), {s[2 + 2 * i], s[3 + 2 * i]}});
      ok = (s[2 + 2 * n] == model_csum(s, n));
      code = ok ? 2'd0 : 2'd2;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start;
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    chk("start_code", 32'(err_code), 32'd0);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ok);
    int n = 0;
    rx_valid = 1'b1;
    rx_byte  = b;
    ok = 1'b0;
    while (!rx_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (rx_ready) begin
      cyc(1);
      ok = 1'b1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input int gmax);
    logic ok;
    foreach (s[i]) begin
      cyc($urandom_range(gmax, 0));
      send_byte(s[i], ok);
      if (!ok) begin
        chk("byte_accept_bound", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic run_load(input bq_t s, input int gmax);
    logic ok;
    logic [1:0] code;
    model_push(s, ok, code);
    pulse_start();
    send_stream(s, gmax);
    chk("final_done", 32'(done), 32'(ok));
    chk("final_error", 32'(error), 32'(!ok));
    chk("final_code", 32'(err_code), 32'(code));
    chk("final_hold", 32'(cpu_hold), 32'(!ok));
    chk("final_ready", 32'(rx_ready), 32'd0);
    chk("writes_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    bq_t q;
    logic ok;
    int n;
    int t;

    cyc(2);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    reset = 1'b1;
    cyc(2);

    // XOR of A1,23,B4,56 is 0x60; pins the model before it is trusted.
    q = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4, 8'h56, 8'h60};
    chk("model_csum_literal", 32'(model_csum(q, 2)), 32'h60);
    run_load(q, 0);
    chk("normal_done_literal", 32'(done), 32'd1);

    q = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4, 8'h56, 8'h66};
    run_load(q, 0);
    chk("bad_csum_literal", 32'(err_code), 32'd2);

    q = '{8'h00, 8'h00, 8'h00};
    run_load(q, 0);
    chk("zero_len_done", 32'(done), 32'd1);
    q = '{8'h00, 8'h00, 8'h01};
    run_load(q, 0);
    chk("zero_len_bad", 32'(err_code), 32'd2);

    q = '{8'h01, 8'h01};
    run_load(q, 0);
    chk("oversize_code", 32'(err_code), 32'd1);
    chk("oversize_ready", 32'(rx_ready), 32'd0);

    q = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) q.push_back(8'(i));
    for (int i = 0; i < 256; i++) q.push_back(8'(255 - i));
    q.push_back(model_csum(q, 256));
    run_load(q, 0);
    chk("max_len_done", 32'(done), 32'd1);

    q = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4, 8'h56, 8'h60};
    run_load(q, 20);

    for (int it = 0; it < 14; it++) begin
      n = (it == 3) ? 0 : $urandom_range(8, 1);
      q = '{8'(n >> 8), 8'(n)};
      for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
      q.push_back(model_csum(q, n) ^ (($urandom % 4 == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00));
      run_load(q, $urandom_range(6, 0));
    end
    n = $urandom_range(600, 257);
    q = '{8'(n >> 8), 8'(n)};
    run_load(q, 2);

    pulse_start();
    q = '{8'h00, 8'h01, 8'hA1};
    send_stream(q, 0);
    cyc(1000);
    chk("timeout_not_yet", 32'(error), 32'd0);
    t = 0;
    while (!error && t < 60) begin
      cyc(1);
      t++;
    end
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_code", 32'(err_code), 32'd3);
    chk("timeout_hold", 32'(cpu_hold), 32'd1);
    q = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4, 8'h56, 8'h60};
    run_load(q, 3);

    exp_wr.push_back('{16'h0000, 16'hA123});
    pulse_start();
    q = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4};
    send_stream(q, 0);
    reset = 1'b0;
    #1;
    chk("mid_ready", 32'(rx_ready), 32'd0);
    chk("mid_we", 32'(imem_we), 32'd0);
    chk("mid_addr", 32'(imem_addr), 32'd0);
    chk("mid_wdata", 32'(imem_wdata), 32'd0);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_error", 32'(error), 32'd0);
    chk("mid_code", 32'(err_code), 32'd0);
    chk("mid_drained", 32'(exp_wr.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("mid_no_we", 32'(imem_we), 32'd0);
    end
    reset = 1'b1;
    cyc(1);
    q = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4, 8'h56, 8'h60};
    run_load(q, 0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
